// File: rtl/register_scoreboard.sv
// Architectural register file with per-register outstanding-write counters.
// Provides RAW-hazard stall, same-cycle write-back bypass and sticky misuse flags.
module register_scoreboard #(
    parameter int unsigned OPERAND_WIDTH             = 32,
    parameter int unsigned REGISTER_DESCRIPTOR_WIDTH = 5,
    parameter int unsigned RESERVE_COUNT_WIDTH       = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 issue_valid_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rs1_addr_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rs2_addr_input,
    input  logic                                 rs1_use_input,
    input  logic                                 rs2_use_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
    input  logic                                 write_reserve_input,
    output logic                                 issue_ready_output,
    output logic [OPERAND_WIDTH-1:0]             rs1_data_output,
    output logic [OPERAND_WIDTH-1:0]             rs2_data_output,
    input  logic                                 write_back_valid_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] write_back_rd_addr_input,
    input  logic [OPERAND_WIDTH-1:0]             write_back_data_input,
    output logic                                 reserved_output,
    output logic                                 underflow_error_output,
    output logic                                 overflow_error_output
);

    localparam int NUM_REGS = 1 << REGISTER_DESCRIPTOR_WIDTH;
    localparam logic [RESERVE_COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [RESERVE_COUNT_WIDTH-1:0] CNT_ONE = RESERVE_COUNT_WIDTH'(1);

    logic [OPERAND_WIDTH-1:0]       regs_q [NUM_REGS];
    logic [RESERVE_COUNT_WIDTH-1:0] cnt_q  [NUM_REGS];
    logic [RESERVE_COUNT_WIDTH-1:0] cnt_d  [NUM_REGS];
    logic                           underflow_q, underflow_d;
    logic                           overflow_q, overflow_d;

    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] src_busy;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                hazard;
    logic                accept;

    // A source whose last outstanding write lands this cycle is bypassed rather than stalled.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wb_hit[i]   = write_back_valid_input && (i != 0) &&
                          (write_back_rd_addr_input == REGISTER_DESCRIPTOR_WIDTH'(i));
            src_busy[i] = (cnt_q[i] != '0) && !(wb_hit[i] && (cnt_q[i] == CNT_ONE));
        end
    end

    always_comb begin
        hazard = (rs1_use_input && src_busy[rs1_addr_input]) ||
                 (rs2_use_input && src_busy[rs2_addr_input]) ||
                 (write_reserve_input && (rd_addr_input != '0) &&
                  (cnt_q[rd_addr_input] == CNT_MAX) && !wb_hit[rd_addr_input]);
        issue_ready_output = !hazard;
        accept             = issue_valid_input && !hazard;

        if (rs1_addr_input == '0) begin
            rs1_data_output = '0;
        end else if (wb_hit[rs1_addr_input]) begin
            rs1_data_output = write_back_data_input;
        end else begin
            rs1_data_output = regs_q[rs1_addr_input];
        end

        if (rs2_addr_input == '0) begin
            rs2_data_output = '0;
        end else if (wb_hit[rs2_addr_input]) begin
            rs2_data_output = write_back_data_input;
        end else begin
            rs2_data_output = regs_q[rs2_addr_input];
        end
    end

    always_comb begin
        underflow_d     = underflow_q;
        overflow_d      = overflow_q;
        reserved_output = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i]   = accept && write_reserve_input && (i != 0) &&
                       (rd_addr_input == REGISTER_DESCRIPTOR_WIDTH'(i));
            dec[i]   = wb_hit[i] && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                // Saturate; hazard logic keeps a legal master from ever getting here.
                if (cnt_q[i] == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
            if (wb_hit[i] && (cnt_q[i] == '0)) begin
                underflow_d = 1'b1;
            end
            if (cnt_q[i] != '0) begin
                reserved_output = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_hit[i]) begin
                    regs_q[i] <= write_back_data_input;
                end
                cnt_q[i] <= cnt_d[i];
            end
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign underflow_error_output = underflow_q;
    assign overflow_error_output  = overflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: a counting model checked every cycle,
// plus literal expectations at the interesting points of the sequence.
module tb_register_scoreboard;

    localparam int OW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk, rst, iv, u1, u2, wr, wbv;
    logic [AW-1:0] rs1, rs2, rd, wba;
    logic [OW-1:0] wbd;
    logic          ready, resv, uf, of;
    logic [OW-1:0] d1, d2;

    register_scoreboard #(
        .OPERAND_WIDTH             (OW),
        .REGISTER_DESCRIPTOR_WIDTH (AW),
        .RESERVE_COUNT_WIDTH       (CW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .issue_valid_input        (iv),
        .rs1_addr_input           (rs1),
        .rs2_addr_input           (rs2),
        .rs1_use_input            (u1),
        .rs2_use_input            (u2),
        .rd_addr_input            (rd),
        .write_reserve_input      (wr),
        .issue_ready_output       (ready),
        .rs1_data_output          (d1),
        .rs2_data_output          (d2),
        .write_back_valid_input   (wbv),
        .write_back_rd_addr_input (wba),
        .write_back_data_input    (wbd),
        .reserved_output          (resv),
        .underflow_error_output   (uf),
        .overflow_error_output    (of)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          m_cnt  [32];
    logic [31:0] m_regs [32];
    bit          m_uf, m_of;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int r);
        return wbv && (int'(wba) == r) && (r != 0);
    endfunction

    function automatic bit m_busy(input int r);
        return (m_cnt[r] != 0) && !(m_hit(r) && m_cnt[r] == 1);
    endfunction

    function automatic bit m_ready();
        return !((u1 && m_busy(int'(rs1))) || (u2 && m_busy(int'(rs2))) ||
                 (wr && rd != 0 && m_cnt[rd] == MAXC && !m_hit(int'(rd))));
    endfunction

    function automatic logic [31:0] m_data(input int r);
        if (r == 0) return 32'h0;
        if (m_hit(r)) return wbd;
        return m_regs[r];
    endfunction

    function automatic bit m_reserved();
        for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit acc;
        bit inc, dec;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i]  = 0;
                m_regs[i] = 32'h0;
            end
            m_uf = 1'b0;
            m_of = 1'b0;
        end else begin
            acc = iv && m_ready();
            for (int i = 1; i < 32; i++) begin
                inc = acc && wr && (int'(rd) == i);
                dec = m_hit(i) && (m_cnt[i] != 0);
                if (m_hit(i)) begin
                    m_regs[i] = wbd;
                    if (m_cnt[i] == 0) m_uf = 1'b1;
                end
                if (inc && !dec) begin
                    if (m_cnt[i] == MAXC) m_of = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end else if (dec && !inc) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_cnt[i]  = 0;
            m_regs[i] = 32'h0;
        end
        m_uf = 1'b0;
        m_of = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_ready",     {31'h0, ready}, {31'h0, m_ready()});
            chk("m_rs1_data",  d1, m_data(int'(rs1)));
            chk("m_rs2_data",  d2, m_data(int'(rs2)));
            chk("m_reserved",  {31'h0, resv}, {31'h0, m_reserved()});
            chk("m_underflow", {31'h0, uf}, {31'h0, m_uf});
            chk("m_overflow",  {31'h0, of}, {31'h0, m_of});
        end
    end

    task automatic idle();
        iv  = 1'b0; u1 = 1'b0; u2 = 1'b0; wr = 1'b0; wbv = 1'b0;
        rs1 = '0;   rs2 = '0;  rd = '0;   wba = '0;  wbd = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic iss(input bit v, input int a1, input bit b1, input int a2, input bit b2,
                       input int d, input bit w);
        iv = v; rs1 = AW'(a1); u1 = b1; rs2 = AW'(a2); u2 = b2; rd = AW'(d); wr = w;
    endtask

    task automatic wbk(input int a, input logic [31:0] d);
        wbv = 1'b1; wba = AW'(a); wbd = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        cyc(); rst = 1'b0; iss(0, 5, 1, 0, 1, 0, 0); #2;
        chk("rst_rs1_x5", d1, 32'h0);
        chk("rst_rs2_x0", d2, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_reserved", {31'h0, resv}, 32'h0);
        chk("rst_flags", {30'h0, uf, of}, 32'h0);

        cyc(); iss(1, 0, 0, 0, 0, 3, 1); #2;
        chk("reserve_x3_ready", {31'h0, ready}, 32'h1);

        cyc(); iss(1, 3, 1, 0, 0, 0, 0); #2;
        chk("raw_stall_x3", {31'h0, ready}, 32'h0);
        chk("reserved_x3", {31'h0, resv}, 32'h1);
        wbk(3, 32'hDEADBEEF); #1;
        chk("wb_bypass_ready", {31'h0, ready}, 32'h1);
        chk("wb_bypass_data", d1, 32'hDEADBEEF);

        cyc(); iss(0, 3, 1, 0, 0, 0, 0); #2;
        chk("x3_from_regs", d1, 32'hDEADBEEF);
        chk("x3_drained", {31'h0, resv}, 32'h0);

        repeat (3) begin
            cyc(); iss(1, 0, 0, 0, 0, 7, 1);
        end
        cyc(); iss(1, 0, 0, 0, 0, 7, 1); #2;
        chk("x7_full_stall", {31'h0, ready}, 32'h0);
        wbk(7, 32'h77); #1;
        chk("x7_full_wb_ready", {31'h0, ready}, 32'h1);

        cyc(); #2;
        chk("x7_no_overflow", {31'h0, of}, 32'h0);
        chk("x7_still_reserved", {31'h0, resv}, 32'h1);
        wbk(7, 32'h78);
        cyc(); wbk(7, 32'h79);
        cyc(); wbk(7, 32'h7A);
        cyc(); iss(0, 7, 1, 0, 0, 0, 0); #2;
        chk("x7_drained", {31'h0, resv}, 32'h0);
        chk("x7_last_value", d1, 32'h7A);

        cyc(); iss(1, 0, 0, 0, 0, 4, 1);
        cyc(); iss(1, 0, 0, 0, 0, 4, 1); wbk(4, 32'h44); #2;
        chk("x4_inc_dec_ready", {31'h0, ready}, 32'h1);
        cyc(); iss(0, 4, 1, 0, 0, 0, 0); #2;
        chk("x4_still_busy", {31'h0, ready}, 32'h0);
        chk("x4_regs_updated", d1, 32'h44);
        cyc(); wbk(4, 32'h45);

        cyc(); wbk(9, 32'h1234); iss(0, 0, 0, 9, 1, 0, 0); #2;
        chk("x9_bypass", d2, 32'h1234);
        chk("x9_uf_before_edge", {31'h0, uf}, 32'h0);
        cyc(); iss(0, 9, 1, 0, 1, 0, 0); wbk(0, 32'hFFFF); #2;
        chk("x9_underflow", {31'h0, uf}, 32'h1);
        chk("x9_stored", d1, 32'h1234);
        chk("x0_wb_read", d2, 32'h0);
        cyc(); iss(0, 0, 1, 0, 0, 0, 0); #2;
        chk("uf_sticky", {31'h0, uf}, 32'h1);
        chk("x0_after_wb", d1, 32'h0);
        chk("x0_wb_no_overflow", {31'h0, of}, 32'h0);

        cyc(); iss(1, 0, 0, 0, 0, 2, 1);
        cyc(); rst = 1'b1; iss(1, 2, 1, 0, 0, 0, 0); #2;
        chk("x2_busy_before_rst", {31'h0, ready}, 32'h0);
        cyc(); rst = 1'b0; iss(1, 2, 1, 3, 1, 0, 0); #2;
        chk("x2_ready_after_rst", {31'h0, ready}, 32'h1);
        chk("rst_drops_reserved", {31'h0, resv}, 32'h0);
        chk("rst_clears_uf", {31'h0, uf}, 32'h0);
        chk("rst_clears_x3", d2, 32'h0);

        cyc(); iss(1, 6, 1, 6, 1, 6, 1); #2;
        chk("x6_self_ready", {31'h0, ready}, 32'h1);
        cyc(); iss(1, 6, 1, 6, 1, 6, 1); #2;
        chk("x6_self_stall", {31'h0, ready}, 32'h0);
        wbk(6, 32'h66); #1;
        chk("x6_self_wb_ready", {31'h0, ready}, 32'h1);
        chk("x6_self_wb_data", d1, 32'h66);
        cyc(); iss(0, 6, 1, 0, 0, 0, 0); wbk(6, 32'h67); #2;
        chk("x6_last_wb_bypass", {31'h0, ready}, 32'h1);
        cyc(); wbk(2, 32'h22);
        cyc(); iss(0, 2, 1, 0, 0, 0, 0); #2;
        chk("post_rst_wb_uf", {31'h0, uf}, 32'h1);
        chk("post_rst_wb_data", d1, 32'h22);
        chk("all_drained", {31'h0, resv}, 32'h0);

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
